// File: rtl/multi_channel_resource_scheduler.sv
// Round-robin arbiter feeding N request channels into one LAT-stage shared increment pipeline.
// Results carry a channel tag; per-channel flush kills that channel's in-flight work.
module multi_channel_resource_scheduler #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 32,
    parameter int LAT    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH*DATA_W-1:0]   req_data,
    output logic [N_CH-1:0]          req_ready,
    input  logic [N_CH-1:0]          flush,
    output logic [N_CH-1:0]          rsp_valid,
    input  logic [N_CH-1:0]          rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [N_CH-1:0]          stall,
    output logic                     global_stall
);

    localparam int TAG_W = (N_CH > 2) ? $clog2(N_CH) : 1;

    logic [LAT-1:0]    vld_p;
    logic [TAG_W-1:0]  tag_p  [LAT];
    logic [DATA_W-1:0] data_p [LAT];
    logic [TAG_W-1:0]  ptr;

    logic              gnt_found;
    logic [TAG_W-1:0]  gnt_idx;
    logic [TAG_W-1:0]  ptr_next;
    logic              xfer;
    logic              out_live;

    function automatic logic [DATA_W-1:0] inc_wrap(input logic [DATA_W-1:0] d);
        return d + DATA_W'(1);
    endfunction

    // Output stage: a flushed entry is masked and can never hold the pipeline.
    assign out_live     = vld_p[LAT-1] & ~flush[tag_p[LAT-1]];
    assign global_stall = out_live & ~rsp_ready[tag_p[LAT-1]];
    assign rsp_data     = data_p[LAT-1];

    always_comb begin
        rsp_valid = '0;
        if (out_live)
            rsp_valid[tag_p[LAT-1]] = 1'b1;
    end

    // First eligible channel at or after ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!gnt_found && req_valid[idx] && !flush[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = TAG_W'(idx);
            end
        end
    end

    assign xfer     = gnt_found & ~global_stall & reset;
    assign ptr_next = TAG_W'((int'(gnt_idx) + 1) % N_CH);

    always_comb begin
        req_ready = '0;
        if (xfer)
            req_ready[gnt_idx] = 1'b1;
    end

    assign stall = reset ? (req_valid & ~req_ready & ~flush) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p <= '0;
            ptr   <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_p[s]  <= '0;
                data_p[s] <= '0;
            end
        end else if (global_stall) begin
            // Frozen: contents hold, but flushed entries still die.
            for (int s = 0; s < LAT; s++)
                vld_p[s] <= vld_p[s] & ~flush[tag_p[s]];
        end else begin
            // Stage 0: granted request enters the resource.
            vld_p[0]  <= xfer;
            tag_p[0]  <= gnt_idx;
            data_p[0] <= inc_wrap(req_data[int'(gnt_idx)*DATA_W +: DATA_W]);
            // Stages 1..LAT-1: shift, dropping flushed entries on the way.
            for (int s = 1; s < LAT; s++) begin
                vld_p[s]  <= vld_p[s-1] & ~flush[tag_p[s-1]];
                tag_p[s]  <= tag_p[s-1];
                data_p[s] <= data_p[s-1];
            end
            if (xfer)
                ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_multi_channel_resource_scheduler.sv
// Randomized bench for multi_channel_resource_scheduler against a queue-of-operations model
// where each in-flight op carries its channel, result and age in advancing cycles.
module tb_multi_channel_resource_scheduler;

    localparam int N_CH   = 4;
    localparam int DATA_W = 32;
    localparam int LAT    = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH*DATA_W-1:0] req_data;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH-1:0]        flush;
    logic [N_CH-1:0]        rsp_valid;
    logic [N_CH-1:0]        rsp_ready;
    logic [DATA_W-1:0]      rsp_data;
    logic [N_CH-1:0]        stall;
    logic                   global_stall;

    multi_channel_resource_scheduler #(.N_CH(N_CH), .DATA_W(DATA_W), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .stall(stall), .global_stall(global_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
        int                age;
    } op_t;

    op_t             inflight[$];
    int              ptr_m;
    int              n_chk  = 0;
    int              n_pass = 0;
    logic [N_CH-1:0] m_gnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [N_CH*DATA_W-1:0] rand_data();
        logic [N_CH*DATA_W-1:0] r;
        for (int k = 0; k < N_CH; k++)
            r[k*DATA_W +: DATA_W] = ($urandom_range(0, 7) == 0) ? {DATA_W{1'b1}} : DATA_W'($urandom);
        return r;
    endfunction

    // One clock cycle: drive, predict, compare, then advance the model at the edge.
    task automatic step(input logic rst_v, input logic [N_CH-1:0] rv,
                        input logic [N_CH*DATA_W-1:0] rd, input logic [N_CH-1:0] fl,
                        input logic [N_CH-1:0] rr);
        int              out_i;
        int              g;
        int              c;
        logic            gs;
        logic [N_CH-1:0] e_rv;
        logic [N_CH-1:0] e_rr;
        logic [N_CH-1:0] e_st;
        logic [DATA_W-1:0] e_rd;
        reset     = rst_v;
        req_valid = rv;
        req_data  = rd;
        flush     = fl;
        rsp_ready = rr;
        if (!rst_v) begin
            inflight.delete();
            ptr_m = 0;
        end
        out_i = -1;
        foreach (inflight[k]) if (inflight[k].age == LAT - 1) out_i = k;
        e_rv = '0;
        e_rd = '0;
        gs   = 1'b0;
        if (out_i >= 0) begin
            e_rd = inflight[out_i].data;
            if (!fl[inflight[out_i].ch]) begin
                e_rv[inflight[out_i].ch] = 1'b1;
                gs = !rr[inflight[out_i].ch];
            end
        end
        g = -1;
        if (rst_v && !gs) begin
            for (int k = 0; k < N_CH; k++) begin
                c = (ptr_m + k) % N_CH;
                if (g < 0 && rv[c] && !fl[c]) g = c;
            end
        end
        e_rr = (g >= 0) ? N_CH'(1 << g) : '0;
        e_st = rst_v ? (rv & ~e_rr & ~fl) : '0;
        #4;
        chk("req_ready", req_ready, e_rr);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("global_stall", global_stall, gs);
        chk("stall", stall, e_st);
        if (e_rv != '0 || !rst_v) chk("rsp_data", rsp_data, e_rd);
        @(posedge clk);
        if (rst_v) begin
            if (!gs) begin
                for (int k = inflight.size() - 1; k >= 0; k--)
                    if (inflight[k].age == LAT - 1) inflight.delete(k);
                foreach (inflight[k]) inflight[k].age = inflight[k].age + 1;
            end
            for (int k = inflight.size() - 1; k >= 0; k--)
                if (fl[inflight[k].ch]) inflight.delete(k);
            if (g >= 0) begin
                inflight.push_back('{ch: g, data: rd[g*DATA_W +: DATA_W] + DATA_W'(1), age: 0});
                ptr_m = (g + 1) % N_CH;
            end
        end
        m_gnt = e_rr;
        #1;
    endtask

    initial begin
        logic [N_CH*DATA_W-1:0] rd;
        logic [N_CH-1:0]        rv;
        logic [N_CH-1:0]        fl;
        logic [N_CH-1:0]        rr;
        int                     sent;
        int                     sent1;
        int                     rst_left;

        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        flush     = '0;
        rsp_ready = '0;
        ptr_m     = 0;
        m_gnt     = '0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int c = 0; c < 3; c++) step(1'b0, '1, rand_data(), '0, '1);

        // all channels requesting: strict rotation, back-to-back responses
        for (int c = 0; c < 8; c++) step(1'b1, '1, rand_data(), '0, '1);
        for (int c = 0; c < 4; c++) step(1'b1, '0, '0, '0, '1);

        // wrap of all-ones on channel 1
        rd = '0;
        rd[1*DATA_W +: DATA_W] = {DATA_W{1'b1}};
        step(1'b1, 4'b0010, rd, '0, '1);
        for (int c = 0; c < LAT + 1; c++) step(1'b1, '0, '0, '0, '1);

        // channel 0 stream 1..4 with response backpressure on channel 0
        sent = 0;
        for (int c = 0; c < 14; c++) begin
            rd = '0;
            rd[0 +: DATA_W] = DATA_W'(sent + 1);
            rv = (sent < 4) ? 4'b0001 : 4'b0000;
            rr = (c >= 3 && c < 7) ? 4'b1110 : 4'b1111;
            step(1'b1, rv, rd, '0, rr);
            if (m_gnt[0]) sent++;
        end

        // channel 1 stuck at output, then flushed while channel 0 flows
        sent1 = 0;
        for (int c = 0; c < 12; c++) begin
            rd = '0;
            rd[0 +: DATA_W]      = DATA_W'(100 + c);
            rd[DATA_W +: DATA_W] = DATA_W'(10 + sent1);
            rv = {2'b00, (sent1 < 3), (c < 6)};
            fl = (c == 8) ? 4'b0010 : 4'b0000;
            step(1'b1, rv, rd, fl, 4'b1101);
            if (m_gnt[1]) sent1++;
        end
        for (int c = 0; c < LAT + 2; c++) step(1'b1, '0, '0, '0, '1);

        // reset with ops in flight
        for (int c = 0; c < 3; c++) step(1'b1, '1, rand_data(), '0, '1);
        for (int c = 0; c < 2; c++) step(1'b0, '1, rand_data(), '0, '1);
        for (int c = 0; c < LAT + 2; c++) step(1'b1, '0, '0, '0, '1);

        // random traffic with flushes, backpressure and occasional reset
        rst_left = 0;
        for (int c = 0; c < 2500; c++) begin
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
            rv = N_CH'($urandom);
            fl = '0;
            rr = '0;
            for (int k = 0; k < N_CH; k++) begin
                fl[k] = ($urandom_range(0, 9) == 0);
                rr[k] = ($urandom_range(0, 3) != 0);
            end
            step(rst_left == 0, rv, rand_data(), fl, rr);
            if (rst_left > 0) rst_left--;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
